sdp_hls_mul_shift_sat: RTL and testbench
========================================

Name: sdp_hls_mul_shift_sat

Overview:
Downstream neighbour of the SDP HLS PReLU/multiply stage. It consumes the signed 64-bit product that stage produces, rounds and arithmetic-right-shifts it by a programmable amount, then saturates the result to a signed 32-bit value. It is a 2-stage valid/ready pipeline and keeps a saturation event counter for register readback.

Parameters:
IN_WIDTH, 64, width of the signed product input.
OUT_WIDTH, 32, width of the signed saturated output.
SHIFT_WIDTH, 6, width of the shift amount; valid range 0..IN_WIDTH-1.
CNT_WIDTH, 32, width of the saturation counter.

Ports:
nvdla_core_clk  input  1  core clock; all flops clock on the rising edge.
nvdla_core_rstn  input  1  asynchronous active-low reset.
cfg_shift  input  SHIFT_WIDTH  right-shift amount; sampled per beat on stage-1 capture.
cfg_cnt_clr  input  1  single-cycle pulse; clears sat_cnt.
in_pvld  input  1  input beat valid.
in_prdy  output  1  input ready.
in_pd  input  IN_WIDTH  signed product from the multiply stage.
out_pvld  output  1  output beat valid.
out_prdy  input  1  downstream ready.
out_pd  output  OUT_WIDTH  signed shifted and saturated result.
sat_cnt  output  CNT_WIDTH  number of output beats that saturated since the last clear.

Behaviour:
- Reset: both stage valids = 0, so out_pvld = 0. out_pd = 0, sat_cnt = 0. in_prdy = 1 once the valids are clear. Reset asserted mid-operation discards all in-flight beats at once, with no output.
- Handshake: a transfer occurs when pvld & prdy in the same cycle.
  - Once out_pvld rises, out_pvld and out_pd hold stable until accepted.
- Pipeline:
  - s1_rdy = !s1_vld | s2_rdy; s2_rdy = !s2_vld | out_prdy; in_prdy = s1_rdy.
  - The input-to-output path is purely registered, with no combinational path from in_pvld/in_pd to out_*. There is a ready chain from out_prdy to in_prdy.
  - Latency is 2 cycles: a beat accepted in cycle N appears on out_pvld in cycle N+2 if not stalled.
  - Throughput is 1 beat/cycle while out_prdy = 1.
  - Ordering is preserved; no beat is dropped or duplicated under any pattern of stalls.
- Stage 1 (round + shift) on capture:
  - Sign-extend in_pd to IN_WIDTH+1 bits.
  - If cfg_shift = 0: r = in_pd unchanged.
  - Else: r = (in_pd + 2^(cfg_shift-1)) >>> cfg_shift, which is round half toward +inf. The add is done in IN_WIDTH+1 bits so no wrap occurs.
  - r is stored in IN_WIDTH+1 bits.
- Stage 2 (saturate) on capture:
  - If r > 2^(OUT_WIDTH-1)-1: out_pd = 0x7FFFFFFF and sat = 1.
  - Else if r < -2^(OUT_WIDTH-1): out_pd = 0x80000000 and sat = 1.
  - Else: out_pd = r[OUT_WIDTH-1:0] and sat = 0.
- sat_cnt:
  - Increments by 1 on each output handshake (out_pvld & out_prdy) whose beat has sat = 1.
  - Saturates at all-ones; it does not wrap.
  - cfg_cnt_clr has priority over a simultaneous increment: the result is 0 and that event is lost.
- cfg_shift changing while beats are in flight affects only beats captured into stage 1 after the change.
- cfg_shift >= IN_WIDTH is illegal; its behaviour is unspecified and assertion-flagged in simulation.

Test Plan:
- Reset, then in_pd=24, cfg_shift=4 with out_prdy=1 -> out_pd=2 exactly 2 cycles after acceptance; sat_cnt=0.
- in_pd=-24, shift=4 -> out_pd=-1 (0xFFFFFFFF). in_pd=-8, shift=4 -> 0. in_pd=7, shift=0 -> 7.
- in_pd=0x0000000100000000, shift=0 -> 0x7FFFFFFF, sat_cnt=1. in_pd=0xFFFFFFFE00000000, shift=0 -> 0x80000000, sat_cnt=2. in_pd=0x7FFFFFFF80000000, shift=32 -> 0x7FFFFFFF (rounding path, not wrapped).
- Stream 8 beats at 1/cycle while out_prdy toggles in the pattern 1,0,0,1,0,1,1,0... -> all 8 results in order, none lost. in_prdy deasserts only when both stages are full and out_prdy=0. out_pd is stable while stalled.
- cfg_cnt_clr coincident with a saturating output handshake -> sat_cnt=0 the next cycle; the next saturating beat gives sat_cnt=1.
- Assert nvdla_core_rstn low for 1 cycle with 2 beats in flight -> out_pvld=0 immediately, and no stale beat appears after reset release.

Source files
------------

// File: rtl/sdp_hls_mul_shift_sat.sv
// sdp_hls_mul_shift_sat: rounds and arithmetic-right-shifts a signed product,
// then saturates it to OUT_WIDTH bits. The block is a two-stage valid/ready
// pipeline with registered outputs, and it counts saturated output beats.

module sdp_hls_mul_shift_sat #(
  parameter int IN_WIDTH    = 64,
  parameter int OUT_WIDTH   = 32,
  parameter int SHIFT_WIDTH = 6,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rstn,
  input  logic [SHIFT_WIDTH-1:0] cfg_shift,
  input  logic                   cfg_cnt_clr,
  input  logic                   in_pvld,
  output logic                   in_prdy,
  input  logic [IN_WIDTH-1:0]    in_pd,
  output logic                   out_pvld,
  input  logic                   out_prdy,
  output logic [OUT_WIDTH-1:0]   out_pd,
  output logic [CNT_WIDTH-1:0]   sat_cnt
);

  // Saturation bounds, sign-extended to the stage-1 width.
  localparam logic signed [IN_WIDTH:0] SAT_MAX =
    {{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [IN_WIDTH:0] SAT_MIN =
    {{(IN_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Round half toward +inf, then shift. The extra bit keeps the bias add from wrapping.
  function automatic logic signed [IN_WIDTH:0] round_shift(
    input logic [IN_WIDTH-1:0]    pd,
    input logic [SHIFT_WIDTH-1:0] sh
  );
    logic signed [IN_WIDTH:0] ext;
    logic signed [IN_WIDTH:0] bias;
    logic signed [IN_WIDTH:0] sum;
    ext  = {pd[IN_WIDTH-1], pd};
    bias = {{IN_WIDTH{1'b0}}, 1'b1};
    if (sh == {SHIFT_WIDTH{1'b0}}) begin
      round_shift = ext;
    end else begin
      bias = bias << (sh - {{(SHIFT_WIDTH-1){1'b0}}, 1'b1});
      sum  = ext + bias;
      round_shift = sum >>> sh;
    end
  endfunction

  // Clamp to OUT_WIDTH signed. The returned value is {sat_flag, value}.
  function automatic logic [OUT_WIDTH:0] saturate(input logic signed [IN_WIDTH:0] r);
    if (r > SAT_MAX) begin
      saturate = {1'b1, OUT_MAX};
    end else if (r < SAT_MIN) begin
      saturate = {1'b1, OUT_MIN};
    end else begin
      saturate = {1'b0, r[OUT_WIDTH-1:0]};
    end
  endfunction

  logic                        s1_vld_q, s1_vld_d;
  logic signed [IN_WIDTH:0]    s1_r_q, s1_r_d;
  logic                        s2_vld_q, s2_vld_d;
  logic [OUT_WIDTH-1:0]        s2_pd_q, s2_pd_d;
  logic                        s2_sat_q, s2_sat_d;
  logic [CNT_WIDTH-1:0]        sat_cnt_q, sat_cnt_d;
  logic                        s1_rdy, s2_rdy, in_fire, out_fire;
  logic [OUT_WIDTH:0]          sat_res;

  // Ready chain plus the next-state logic for both stages and the counter.
  always_comb begin
    s2_rdy    = !s2_vld_q | out_prdy;
    s1_rdy    = !s1_vld_q | s2_rdy;
    in_fire   = in_pvld & s1_rdy;
    out_fire  = s2_vld_q & out_prdy;
    sat_res   = saturate(s1_r_q);
    s1_vld_d  = s1_vld_q;
    s1_r_d    = s1_r_q;
    s2_vld_d  = s2_vld_q;
    s2_pd_d   = s2_pd_q;
    s2_sat_d  = s2_sat_q;
    sat_cnt_d = sat_cnt_q;
    if (s1_rdy) begin
      s1_vld_d = in_pvld;
    end else begin
      s1_vld_d = s1_vld_q;
    end
    if (in_fire) begin
      s1_r_d = round_shift(in_pd, cfg_shift);
    end else begin
      s1_r_d = s1_r_q;
    end
    if (s2_rdy) begin
      s2_vld_d = s1_vld_q;
    end else begin
      s2_vld_d = s2_vld_q;
    end
    if (s2_rdy & s1_vld_q) begin
      s2_pd_d  = sat_res[OUT_WIDTH-1:0];
      s2_sat_d = sat_res[OUT_WIDTH];
    end else begin
      s2_pd_d  = s2_pd_q;
      s2_sat_d = s2_sat_q;
    end
    // A clear wins over an increment in the same cycle, and that event is lost.
    if (cfg_cnt_clr) begin
      sat_cnt_d = {CNT_WIDTH{1'b0}};
    end else if (out_fire & s2_sat_q & (sat_cnt_q != CNT_MAX)) begin
      sat_cnt_d = sat_cnt_q + CNT_ONE;
    end else begin
      sat_cnt_d = sat_cnt_q;
    end
  end

  // Pipeline and counter registers. Reset drops every in-flight beat.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      s1_vld_q  <= 1'b0;
      s1_r_q    <= {(IN_WIDTH+1){1'b0}};
      s2_vld_q  <= 1'b0;
      s2_pd_q   <= {OUT_WIDTH{1'b0}};
      s2_sat_q  <= 1'b0;
      sat_cnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_r_q    <= s1_r_d;
      s2_vld_q  <= s2_vld_d;
      s2_pd_q   <= s2_pd_d;
      s2_sat_q  <= s2_sat_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign in_prdy  = s1_rdy;
  assign out_pvld = s2_vld_q;
  assign out_pd   = s2_pd_q;
  assign sat_cnt  = sat_cnt_q;

  sdp_hls_mul_shift_sat_chk #(
    .IN_WIDTH    (IN_WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_chk (
    .clk       (nvdla_core_clk),
    .rst_n     (nvdla_core_rstn),
    .in_fire   (in_fire),
    .cfg_shift (cfg_shift)
  );

endmodule

// Flags an accepted beat that carries a shift amount at or beyond the input width.
module sdp_hls_mul_shift_sat_chk #(
  parameter int IN_WIDTH    = 64,
  parameter int SHIFT_WIDTH = 6
) (
  input logic                   clk,
  input logic                   rst_n,
  input logic                   in_fire,
  input logic [SHIFT_WIDTH-1:0] cfg_shift
);

  function automatic bit shift_ok(input int s);
    return (s < IN_WIDTH);
  endfunction

  a_shift_legal: assert property (@(posedge clk) disable iff (!rst_n)
    in_fire |-> shift_ok(int'(cfg_shift)))
    else $error("cfg_shift out of range");

endmodule

// File: tb/tb_sdp_hls_mul_shift_sat.sv
// Scoreboard bench for sdp_hls_mul_shift_sat. Directed beats push their
// hand-computed results into a queue, and a negedge monitor checks them.
module tb_sdp_hls_mul_shift_sat;

  logic        nvdla_core_clk = 1'b0;
  logic        nvdla_core_rstn = 1'b0;
  logic [5:0]  cfg_shift = 6'd0;
  logic        cfg_cnt_clr = 1'b0;
  logic        in_pvld = 1'b0;
  logic        in_prdy;
  logic [63:0] in_pd = 64'd0;
  logic        out_pvld;
  logic        out_prdy = 1'b1;
  logic [31:0] out_pd;
  logic [31:0] sat_cnt;

  logic [31:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int acc_n, out_n;
  logic        hold_v = 1'b0;
  logic [31:0] hold_pd = 32'd0;
  logic [7:0]  pat = 8'b0110_1001;

  sdp_hls_mul_shift_sat dut (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .cfg_shift       (cfg_shift),
    .cfg_cnt_clr     (cfg_cnt_clr),
    .in_pvld         (in_pvld),
    .in_prdy         (in_prdy),
    .in_pd           (in_pd),
    .out_pvld        (out_pvld),
    .out_prdy        (out_prdy),
    .out_pd          (out_pd),
    .sat_cnt         (sat_cnt)
  );

  always #5 nvdla_core_clk = ~nvdla_core_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Offer one beat and hold in_pvld high. Its result is queued when the handshake is certain.
  task automatic send(input logic [63:0] pd, input logic [5:0] sh, input logic [31:0] exp);
    int g = 0;
    in_pd = pd;
    cfg_shift = sh;
    in_pvld = 1'b1;
    @(negedge nvdla_core_clk);
    while (!in_prdy && g < 50) begin
      @(negedge nvdla_core_clk);
      g++;
    end
    if (!in_prdy) begin
      chk("send_timeout", 64'd0, 64'd1);
    end else begin
      exp_q.push_back(exp);
    end
    @(posedge nvdla_core_clk);
    #1;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(negedge nvdla_core_clk);
      g++;
    end
    chk("drain_done", 64'(exp_q.size()), 64'd0);
    @(posedge nvdla_core_clk);
    #1;
  endtask

  // Count beats accepted and delivered, to model the expected value of in_prdy.
  always @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      acc_n <= 0;
      out_n <= 0;
    end else begin
      if (in_pvld && in_prdy) acc_n <= acc_n + 1;
      if (out_pvld && out_prdy) out_n <= out_n + 1;
    end
  end

  // Monitor: output stability under stall, the in_prdy model, and the scoreboard pop.
  initial begin
    forever begin
      @(negedge nvdla_core_clk);
      if (!nvdla_core_rstn) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) chk("hold_stable", {31'd0, out_pvld, out_pd}, {31'd0, 1'b1, hold_pd});
        chk("in_prdy", 64'(in_prdy), 64'(!(((acc_n - out_n) == 2) && !out_prdy)));
        if (out_pvld && out_prdy) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 64'(out_pd), 64'hDEAD_0000_0000_0000);
          end else begin
            chk("out_pd", 64'(out_pd), 64'(exp_q.pop_front()));
          end
        end
        hold_v  = out_pvld && !out_prdy;
        hold_pd = out_pd;
      end
    end
  end

  initial begin
    repeat (3) @(posedge nvdla_core_clk);
    #1;
    chk("rst_out_pvld", 64'(out_pvld), 64'd0);
    chk("rst_out_pd", 64'(out_pd), 64'd0);
    chk("rst_sat_cnt", 64'(sat_cnt), 64'd0);
    chk("rst_in_prdy", 64'(in_prdy), 64'd1);
    #2 nvdla_core_rstn = 1'b1;
    @(posedge nvdla_core_clk);
    #1;

    // Single beat: latency, then value.
    send(64'd24, 6'd4, 32'd2);
    in_pvld = 1'b0;
    chk("lat_n1_pvld", 64'(out_pvld), 64'd0);
    @(posedge nvdla_core_clk);
    #1;
    chk("lat_n2_pvld", 64'(out_pvld), 64'd1);
    chk("lat_n2_pd", 64'(out_pd), 64'd2);
    drain();
    chk("sat_cnt_0", 64'(sat_cnt), 64'd0);

    // Rounding around zero, plus the unshifted path.
    send(-64'sd24, 6'd4, 32'hFFFF_FFFF);
    send(-64'sd8, 6'd4, 32'd0);
    send(64'd7, 6'd0, 32'd7);
    send(64'd5, 6'd1, 32'd3);
    send(-64'sd5, 6'd1, 32'hFFFF_FFFE);
    send(64'h8000_0000_0000_0000, 6'd63, 32'hFFFF_FFFF);
    in_pvld = 1'b0;
    drain();
    chk("sat_cnt_still_0", 64'(sat_cnt), 64'd0);

    // Saturation: positive, negative, and the rounding carry that must not wrap.
    send(64'h0000_0001_0000_0000, 6'd0, 32'h7FFF_FFFF);
    in_pvld = 1'b0;
    drain();
    chk("sat_cnt_1", 64'(sat_cnt), 64'd1);
    send(64'hFFFF_FFFE_0000_0000, 6'd0, 32'h8000_0000);
    in_pvld = 1'b0;
    drain();
    chk("sat_cnt_2", 64'(sat_cnt), 64'd2);
    send(64'h7FFF_FFFF_8000_0000, 6'd32, 32'h7FFF_FFFF);
    send(64'h0000_0000_7FFF_FFFF, 6'd0, 32'h7FFF_FFFF);
    send(64'hFFFF_FFFF_8000_0000, 6'd0, 32'h8000_0000);
    send(64'h0000_0000_8000_0000, 6'd0, 32'h7FFF_FFFF);
    in_pvld = 1'b0;
    drain();
    chk("sat_cnt_4", 64'(sat_cnt), 64'd4);

    // Streaming under a toggling downstream ready.
    fork
      begin
        for (int i = 0; i < 8; i++) send(64'(i * 16 + 6), 6'd2, 32'(i * 4 + 2));
        in_pvld = 1'b0;
      end
      begin
        for (int k = 0; k < 24; k++) begin
          out_prdy = pat[k % 8];
          @(posedge nvdla_core_clk);
          #1;
        end
        out_prdy = 1'b1;
      end
    join
    drain();
    chk("sat_cnt_stream", 64'(sat_cnt), 64'd4);

    // A clear on the same edge as a saturating handshake leaves zero.
    out_prdy = 1'b0;
    send(64'h0000_0001_0000_0000, 6'd0, 32'h7FFF_FFFF);
    in_pvld = 1'b0;
    for (int g = 0; g < 10 && !out_pvld; g++) @(negedge nvdla_core_clk);
    chk("clr_pvld_ready", 64'(out_pvld), 64'd1);
    @(posedge nvdla_core_clk);
    #1;
    cfg_cnt_clr = 1'b1;
    out_prdy = 1'b1;
    @(posedge nvdla_core_clk);
    #1;
    cfg_cnt_clr = 1'b0;
    chk("clr_wins", 64'(sat_cnt), 64'd0);
    send(64'hFFFF_FFFE_0000_0000, 6'd0, 32'h8000_0000);
    in_pvld = 1'b0;
    drain();
    chk("clr_then_1", 64'(sat_cnt), 64'd1);

    // Mid-flight reset discards both stages immediately.
    out_prdy = 1'b0;
    send(64'd100, 6'd0, 32'd100);
    send(64'd200, 6'd0, 32'd200);
    in_pvld = 1'b0;
    #2 nvdla_core_rstn = 1'b0;
    #1;
    chk("midrst_out_pvld", 64'(out_pvld), 64'd0);
    chk("midrst_in_prdy", 64'(in_prdy), 64'd1);
    chk("midrst_sat_cnt", 64'(sat_cnt), 64'd0);
    exp_q.delete();
    @(posedge nvdla_core_clk);
    #3 nvdla_core_rstn = 1'b1;
    out_prdy = 1'b1;
    repeat (6) @(posedge nvdla_core_clk);
    #1;
    chk("post_rst_no_beat", 64'(out_pvld), 64'd0);
    chk("post_rst_acc", 64'(out_n), 64'd0);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
